// File: rtl/banked_register_file.sv
// banked_register_file: multi-context register file with hardwired r0, capture paths and a sequential context clear.
// Optional same-cycle general-port forwarding on reads when REG_BANK_BYPASS_EN is defined.
module banked_register_file #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int CTX_WIDTH    = 2,
  parameter int INTRPT_WIDTH = 6,
  parameter int LINK_REG     = 31,
  parameter int SYS_REG      = 28
) (
  input  logic                    clk_write,
  input  logic                    rst_n,
  input  logic                    write_flag,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [CTX_WIDTH-1:0]    write_ctx,
  input  logic [DATA_WIDTH-1:0]   data_write,
  input  logic                    jal,
  input  logic [DATA_WIDTH-1:0]   PC,
  input  logic [INTRPT_WIDTH-1:0] intrpt,
  input  logic [1:0]              pc_operation,
  input  logic [DATA_WIDTH-1:0]   PROC_PC,
  input  logic [ADDR_WIDTH-1:0]   read_address_1,
  input  logic [ADDR_WIDTH-1:0]   read_address_2,
  input  logic [CTX_WIDTH-1:0]    read_ctx,
  input  logic                    hlt,
  input  logic                    clr_req,
  input  logic [CTX_WIDTH-1:0]    clr_ctx,
  output logic [DATA_WIDTH-1:0]   data_1,
  output logic [DATA_WIDTH-1:0]   data_2,
  output logic [DATA_WIDTH-1:0]   data_3,
  output logic [DATA_WIDTH-1:0]   value_address,
  output logic                    clr_busy,
  output logic                    clr_done
);
  localparam logic [ADDR_WIDTH-1:0] LINK_IDX = ADDR_WIDTH'(LINK_REG);
  localparam logic [ADDR_WIDTH-1:0] SYS_IDX  = ADDR_WIDTH'(SYS_REG);
  localparam logic [CTX_WIDTH-1:0]  SYS_CTX  = '0;
  localparam bit LINK_OK = LINK_REG != 0;
  localparam bit SYS_OK  = SYS_REG != 0;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] regs [2**CTX_WIDTH][2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] cnt;
  logic [CTX_WIDTH-1:0]  clr_ctx_q;
  logic [DATA_WIDTH-1:0] pc_inc, fwd_data;
  logic [2:0]            hit;
  assign pc_inc = PC + DATA_WIDTH'(1);
  always_comb begin
    state_nx = state;
    if (state == IDLE && clr_req) state_nx = CLEAR;
    else if (state == CLEAR && cnt == '1) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk_write or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      clr_ctx_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && clr_req) begin
        clr_ctx_q <= clr_ctx;
        cnt       <= '0;
      end else if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  // Later assignments win: clear overrides system capture, which overrides the general port.
  always_ff @(posedge clk_write or negedge rst_n)
    if (!rst_n) regs <= '{default: '{default: '0}};
    else begin
      if (jal) begin
        if (LINK_OK) regs[write_ctx][LINK_IDX] <= pc_inc;
      end else if (write_flag && write_address != '0) regs[write_ctx][write_address] <= data_write;
      if (SYS_OK && intrpt != '0) regs[SYS_CTX][SYS_IDX] <= DATA_WIDTH'(intrpt);
      else if (SYS_OK && pc_operation == 2'b01) regs[SYS_CTX][SYS_IDX] <= PROC_PC;
      if (state == CLEAR) regs[clr_ctx_q][cnt] <= '0;
    end
`ifdef REG_BANK_BYPASS_EN
  logic                  fwd_en;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  assign fwd_en   = (jal || write_flag) && read_ctx == write_ctx;
  assign fwd_addr = jal ? LINK_IDX : write_address;
  assign fwd_data = jal ? pc_inc : data_write;
  assign hit = {fwd_en && write_address == fwd_addr,
                fwd_en && read_address_2 == fwd_addr,
                fwd_en && read_address_1 == fwd_addr};
`else
  assign fwd_data = '0;
  assign hit      = '0;
`endif
  assign data_1 = read_address_1 == '0 ? '0 : hit[0] ? fwd_data : regs[read_ctx][read_address_1];
  assign data_2 = read_address_2 == '0 ? '0 : hit[1] ? fwd_data : regs[read_ctx][read_address_2];
  assign data_3 = write_address  == '0 ? '0 : hit[2] ? fwd_data : regs[read_ctx][write_address];
  assign value_address = hlt ? data_1 : '0;
  assign clr_busy = state == CLEAR;
  assign clr_done = state == DONE;
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: scoreboard-driven check of reads, writes, captures, clear engine and reset abort.
module tb_banked_register_file;
  logic        clk_write = 0, rst_n = 0;
  logic        write_flag = 0, jal = 0, hlt = 0, clr_req = 0;
  logic [4:0]  write_address = 0, read_address_1 = 0, read_address_2 = 0;
  logic [1:0]  write_ctx = 0, read_ctx = 0, clr_ctx = 0, pc_operation = 0;
  logic [31:0] data_write = 0, PC = 0, PROC_PC = 0;
  logic [5:0]  intrpt = 0;
  logic [31:0] data_1, data_2, data_3, value_address;
  logic        clr_busy, clr_done;
  logic [31:0] model [4][32];
  logic [31:0] exp_q [$];
  int errors = 0, checks = 0, n;

  banked_register_file dut (
    .clk_write(clk_write), .rst_n(rst_n), .write_flag(write_flag), .write_address(write_address),
    .write_ctx(write_ctx), .data_write(data_write), .jal(jal), .PC(PC), .intrpt(intrpt),
    .pc_operation(pc_operation), .PROC_PC(PROC_PC), .read_address_1(read_address_1),
    .read_address_2(read_address_2), .read_ctx(read_ctx), .hlt(hlt), .clr_req(clr_req),
    .clr_ctx(clr_ctx), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .value_address(value_address), .clr_busy(clr_busy), .clr_done(clr_done));

  always #5 clk_write = ~clk_write;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) for (int a = 0; a < 32; a++) model[c][a] = 0;
  endtask

  // Advance one edge, applying the bench's view of what the edge stores.
  task automatic tick();
    @(posedge clk_write);
    if (jal) model[write_ctx][31] = PC + 1;
    else if (write_flag && write_address != 0) model[write_ctx][write_address] = data_write;
    if (intrpt != 0) model[0][28] = {26'd0, intrpt};
    else if (pc_operation == 2'b01) model[0][28] = PROC_PC;
    #1;
  endtask

  task automatic probe(input string tag, input logic [1:0] c, input logic [4:0] a);
    read_ctx = c; read_address_1 = a;
    exp_q.push_back(a == 0 ? 32'd0 : model[c][a]);
    #1;
    chk(tag, data_1, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d);
    write_flag = 1; write_ctx = c; write_address = a; data_write = d;
    tick();
    write_flag = 0;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1;
    @(negedge clk_write);
    chk("rst_busy", {31'd0, clr_busy}, 0);
    chk("rst_done", {31'd0, clr_done}, 0);
    for (int c = 0; c < 4; c++) for (int a = 0; a < 32; a++) probe("rst_rd", 2'(c), 5'(a));
    read_address_2 = 9; write_address = 17; read_ctx = 3; #1;
    chk("rst_d2", data_2, 0);
    chk("rst_d3", data_3, 0);

    wr(2, 5, 32'hDEADBEEF);
    probe("wr_c2a5", 2, 5);
    probe("wr_c1a5", 1, 5);
    wr(2, 0, 32'h12345678);
    probe("wr_r0", 2, 0);
    read_ctx = 2; read_address_2 = 5; write_address = 5; #1;
    chk("wr_d2", data_2, 32'hDEADBEEF);
    chk("wr_d3", data_3, 32'hDEADBEEF);
    read_address_1 = 5; hlt = 1; #1;
    chk("hlt_on", value_address, 32'hDEADBEEF);
    hlt = 0; #1;
    chk("hlt_off", value_address, 0);

    wr(1, 31, 32'h77);
    jal = 1; write_flag = 1; write_ctx = 1; write_address = 5; data_write = 32'h1234; PC = 32'hFFFFFFFF;
    tick();
    jal = 0; write_flag = 0;
    probe("jal_link", 1, 31);
    chk("jal_link_k", data_1, 32'h0);
    probe("jal_nowr", 1, 5);
    PC = 32'h40; jal = 1; write_ctx = 3;
    tick();
    jal = 0;
    probe("jal_pc", 3, 31);

    intrpt = 6'h2A; pc_operation = 2'b01; PROC_PC = 32'h999;
    tick();
    probe("sys_int", 0, 28);
    chk("sys_int_k", data_1, 32'h2A);
    intrpt = 0; PROC_PC = 32'h100;
    tick();
    probe("sys_proc", 0, 28);
    pc_operation = 2'b10; PROC_PC = 32'h555;
    tick();
    pc_operation = 0;
    probe("sys_noop", 0, 28);
    write_flag = 1; write_ctx = 0; write_address = 28; data_write = 32'hAB; intrpt = 6'h3;
    tick();
    write_flag = 0; intrpt = 0;
    probe("sys_prio", 0, 28);

    wr(0, 7, 32'h11);
    write_flag = 1; write_ctx = 0; write_address = 7; data_write = 32'h55;
    read_ctx = 0; read_address_1 = 7;
`ifdef REG_BANK_BYPASS_EN
    exp_q.push_back(32'h55);
`else
    exp_q.push_back(32'h11);
`endif
    #1;
    chk("byp_same", data_1, exp_q.pop_front());
    tick();
    write_flag = 0;
    probe("byp_after", 0, 7);

    for (int a = 1; a < 32; a++) wr(3, 5'(a), 32'hC000_0000 | a);
    probe("fill_c3", 3, 17);
    clr_req = 1; clr_ctx = 3;
    tick();
    clr_req = 0;
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 5) begin clr_req = 1; clr_ctx = 0; end
      else clr_req = 0;
      n++;
      @(posedge clk_write); #1;
    end
    clr_req = 0;
    chk("clr_busy_len", n, 32);
    chk("clr_done_hi", {31'd0, clr_done}, 1);
    tick();
    chk("clr_done_lo", {31'd0, clr_done}, 0);
    chk("clr_idle", {31'd0, clr_busy}, 0);
    for (int a = 0; a < 32; a++) model[3][a] = 0;
    for (int a = 0; a < 32; a++) probe("clr_c3", 3, 5'(a));
    probe("keep_c0_7", 0, 7);
    probe("keep_c0_28", 0, 28);
    probe("keep_c2_5", 2, 5);
    probe("keep_c1_31", 1, 31);

    wr(1, 9, 32'h9999);
    clr_req = 1; clr_ctx = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'd0, clr_busy}, 1);
    @(negedge clk_write);
    rst_n = 0;
    #1;
    model_reset();
    chk("abort_busy", {31'd0, clr_busy}, 0);
    chk("abort_done", {31'd0, clr_done}, 0);
    probe("abort_c2", 2, 5);
    probe("abort_c1", 1, 20);
    @(negedge clk_write);
    rst_n = 1;
    tick();
    tick();
    chk("post_idle", {31'd0, clr_busy}, 0);
    chk("post_done", {31'd0, clr_done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/banked_register_file.md
# banked_register_file

Multi-context general-purpose register file for the BM core. Holds 2**CTX_WIDTH independent banks of 2**ADDR_WIDTH registers, with independent read and write context selects for context swaps. Adds hardwired-zero r0, asynchronous reset and a sequential per-context clear engine. Sits between decode (read addresses) and writeback (write port), with the link and system-register capture paths used by jal, interrupts and process switches.

## Interface
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers per context
- DATA_WIDTH, 32, register width
- CTX_WIDTH, 2, context select width; 2**CTX_WIDTH contexts
- INTRPT_WIDTH, 6, interrupt code width
- LINK_REG, 31, jal destination index
- SYS_REG, 28, interrupt/PROC_PC capture index (context 0 only)

Ports:
- clk_write  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_flag  in  1  general write enable
- write_address  in  ADDR_WIDTH  write index (rd); also data_3 read index
- write_ctx  in  CTX_WIDTH  context for writes and jal
- data_write  in  DATA_WIDTH  write data
- jal  in  1  write PC+1 to LINK_REG of write_ctx
- PC  in  DATA_WIDTH  current PC
- intrpt  in  INTRPT_WIDTH  nonzero = interrupt code capture
- pc_operation  in  2  2'b01 = capture PROC_PC
- PROC_PC  in  DATA_WIDTH  saved process PC
- read_address_1, read_address_2  in  ADDR_WIDTH  rs, rt
- read_ctx  in  CTX_WIDTH  context for all reads
- hlt  in  1  enables value_address
- clr_req  in  1  start clearing context clr_ctx
- clr_ctx  in  CTX_WIDTH  context to clear
- data_1, data_2, data_3  out  DATA_WIDTH  combinational reads
- value_address  out  DATA_WIDTH  hlt ? data_1 : 0
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle clear completion pulse

## Operation
- Reset (rst_n low, async): every entry of every context = 0; FSM = IDLE; counter = 0; clr_busy = 0, clr_done = 0; data outputs then read 0.
- Reads: entry [read_ctx][addr]; index 0 always reads 0 regardless of contents.
- Writes to index 0 (any source except clear) are discarded.
- General port: jal has priority over write_flag; jal writes (PC + 1) mod 2**DATA_WIDTH to [write_ctx][LINK_REG].
- System capture to [0][SYS_REG]: intrpt != 0 writes intrpt zero-extended; else pc_operation == 2'b01 writes PROC_PC; other pc_operation codes no-op.
- Same-entry conflict on one edge: clear > system capture > general port.
- Clear FSM: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 latches clr_ctx, counter = 0, -> CLEAR.
  - CLEAR: each edge writes 0 to [latched ctx][counter], counter+1; at counter = 2**ADDR_WIDTH-1 -> DONE.
  - DONE: clr_done=1 for this cycle; -> IDLE next edge.
  - clr_req outside IDLE is ignored (no queueing).
- Writes to the context being cleared still occur on non-conflicting entries; entries not yet reached by the counter get overwritten to 0 later.

## Timing
- Read latency: combinational, 0 cycles.
- Write latency: visible on reads the cycle after the capturing edge (without bypass).
- clr_busy high exactly 2**ADDR_WIDTH cycles (32 at default), starting the cycle after the clr_req edge; clr_done high the following single cycle; earliest next accepted clr_req is during the clr_done cycle... no: first edge after returning to IDLE.
- Reset asserted mid-clear aborts immediately; state after release is full reset state.

## Configuration
- REG_BANK_BYPASS_EN defined: data_1/data_2/data_3 forward the same-cycle general-port value (jal or write_flag) when read_ctx == write_ctx and read index == target index, index != 0; system capture and clear are not forwarded.
- Undefined: reads return pre-edge array contents only.

## Test plan
- Reset, then read all ctx/indices -> all 0; clr_busy = clr_done = 0.
- write_flag, ctx 2, addr 5, data 0xDEADBEEF; read_ctx 2 addr 5 next cycle -> 0xDEADBEEF; read_ctx 1 addr 5 -> 0; write addr 0 -> still reads 0.
- jal with write_flag=1, PC=0xFFFFFFFF, ctx 1 -> [1][31] = 0x00000000; write_flag data not stored.
- intrpt=6'h2A and pc_operation=01 same edge -> [0][28] = 0x2A; next edge intrpt=0, pc_operation=01, PROC_PC=0x100 -> 0x100.
- Fill ctx 3, clr_req ctx 3 -> clr_busy 32 cycles, clr_done 1 cycle, ctx 3 all 0, ctx 0-2 intact; second clr_req mid-clear ignored; rst_n low at cycle 10 -> FSM IDLE.
- With REG_BANK_BYPASS_EN: write ctx 0 addr 7 = 0x55 while reading addr 7 -> data_1 = 0x55 same cycle; without macro -> old value.
